// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, one symbol per accepted bit, one register stage.
// Optional zero-tail frame termination is built when CONV_ENC_TAIL_EN is defined.
module conv_encoder #(
   parameter int             K  = 3,
   parameter logic [K-1:0]   G0 = 3'o7,
   parameter logic [K-1:0]   G1 = 3'o5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  logic       i_in_bit,
   input  logic       i_in_last,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic [1:0] o_out_sym,
   output logic       o_out_last
);

   logic [K-2:0] r_sr;
   logic         r_out_valid;
   logic [1:0]   r_out_sym;
   logic         r_out_last;

   logic         w_free;
   logic         w_in_ready;
   logic         w_xfer;
   logic         w_u;
   logic [K-1:0] w_win;
   logic         w_p0;
   logic         w_p1;

   // Output slot is free when empty or being drained this cycle.
   assign w_free = !r_out_valid || i_out_ready;
   assign w_xfer = i_in_valid && w_in_ready;
   assign w_u    = w_xfer & i_in_bit;
   assign w_win  = {w_u, r_sr};
   assign w_p0   = ^(w_win & G0);
   assign w_p1   = ^(w_win & G1);

`ifdef CONV_ENC_TAIL_EN
   localparam int TCW = $clog2(K);

   typedef enum logic {S_DATA, S_TAIL} state_t;

   state_t         r_state;
   logic [TCW-1:0] r_tc;
   logic           w_step;

   assign w_in_ready = (r_state == S_DATA) && w_free;
   assign w_step     = w_xfer || ((r_state == S_TAIL) && w_free);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_DATA;
         r_tc        <= '0;
         r_sr        <= '0;
         r_out_valid <= 1'b0;
         r_out_sym   <= 2'b00;
         r_out_last  <= 1'b0;
      end else if (w_step) begin
         r_sr        <= w_win[K-1:1];
         r_out_sym   <= {w_p0, w_p1};
         r_out_valid <= 1'b1;
         if (r_state == S_DATA) begin
            r_out_last <= 1'b0;
            if (i_in_last) begin
               r_state <= S_TAIL;
               r_tc    <= TCW'(K-1);
            end
         end else begin
            // Tail bits flush the history so the decoder ends in state 0.
            r_tc       <= r_tc - TCW'(1);
            r_out_last <= (r_tc == TCW'(1));
            if (r_tc == TCW'(1))
               r_state <= S_DATA;
         end
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`else
   assign w_in_ready = w_free;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sr        <= '0;
         r_out_valid <= 1'b0;
         r_out_sym   <= 2'b00;
         r_out_last  <= 1'b0;
      end else if (w_xfer) begin
         // Truncated trellis: history restarts from zero at each frame boundary.
         r_sr        <= i_in_last ? '0 : w_win[K-1:1];
         r_out_sym   <= {w_p0, w_p1};
         r_out_last  <= i_in_last;
         r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_sym   = r_out_sym;
   assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_conv_encoder.sv
// Table-driven bench for conv_encoder (K=3, G0=7, G1=5), covering both termination builds.
module tb_conv_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_sym;
   logic       out_last;

   int n_cmp = 0;
   int n_err = 0;

   conv_encoder dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_bit    (in_bit),
      .i_in_last   (in_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_sym   (out_sym),
      .o_out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic       b;
      logic       l;
      logic       ordy;
      logic       irdy;
      logic       ov;
      logic [1:0] sym;
      logic       last;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic v, input logic b, input logic l, input logic ordy,
                      input logic irdy, input logic ov, input logic [1:0] sym, input logic last);
      vec_t e;
      e.rst = r; e.v = v; e.b = b; e.l = l; e.ordy = ordy;
      e.irdy = irdy; e.ov = ov; e.sym = sym; e.last = last;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input int row, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;

`ifdef CONV_ENC_TAIL_EN
      // frame 1,0,1,1 with continuous ready, then two tail symbols
      add(0,1,1,0,1, 1,1,2'b11,0);
      add(0,1,0,0,1, 1,1,2'b10,0);
      add(0,1,1,0,1, 1,1,2'b00,0);
      add(0,1,1,1,1, 1,1,2'b01,0);
      add(0,1,1,0,1, 0,1,2'b01,0);   // in_valid during tail is refused
      add(0,1,1,0,1, 0,1,2'b11,1);
      // two back-to-back single-bit frames
      add(0,1,1,1,1, 1,1,2'b11,0);
      add(0,0,0,0,1, 0,1,2'b10,0);
      add(0,0,0,0,1, 0,1,2'b11,1);
      add(0,1,1,1,1, 1,1,2'b11,0);
      add(0,0,0,0,1, 0,1,2'b10,0);
      add(0,0,0,0,1, 0,1,2'b11,1);
      add(0,0,0,0,1, 1,0,2'b11,1);
      // backpressure, out_ready 1,0,0,1,...
      add(0,1,1,0,1, 1,1,2'b11,0);
      add(0,1,0,0,0, 0,1,2'b11,0);
      add(0,1,0,0,0, 0,1,2'b11,0);
      add(0,1,0,0,1, 1,1,2'b10,0);
      add(0,1,1,0,0, 0,1,2'b10,0);
      add(0,1,1,0,0, 0,1,2'b10,0);
      add(0,1,1,0,1, 1,1,2'b00,0);
      add(0,1,1,1,0, 0,1,2'b00,0);
      add(0,1,1,1,0, 0,1,2'b00,0);
      add(0,1,1,1,1, 1,1,2'b01,0);
      add(0,0,0,0,0, 0,1,2'b01,0);
      add(0,0,0,0,0, 0,1,2'b01,0);
      add(0,0,0,0,1, 0,1,2'b01,0);
      add(0,0,0,0,0, 0,1,2'b01,0);
      add(0,0,0,0,0, 0,1,2'b01,0);
      add(0,0,0,0,1, 0,1,2'b11,1);
      add(0,0,0,0,0, 0,1,2'b11,1);
      add(0,0,0,0,1, 1,0,2'b11,1);
      // reset after two accepted bits, then a single-bit frame
      add(0,1,1,0,1, 1,1,2'b11,0);
      add(0,1,1,0,1, 1,1,2'b01,0);
      add(1,0,0,0,0, 0,0,2'b00,0);
      add(0,1,1,1,0, 1,1,2'b11,0);
      add(0,0,0,0,1, 0,1,2'b10,0);
      add(0,0,0,0,1, 0,1,2'b11,1);
      add(0,0,0,0,1, 1,0,2'b11,1);
`else
      // truncated frame 1,0,1,1 then a single-bit frame
      add(0,1,1,0,1, 1,1,2'b11,0);
      add(0,1,0,0,1, 1,1,2'b10,0);
      add(0,1,1,0,1, 1,1,2'b00,0);
      add(0,1,1,1,1, 1,1,2'b01,1);
      add(0,1,1,1,1, 1,1,2'b11,1);
      add(0,0,0,0,1, 1,0,2'b11,1);
      // backpressure; unaccepted garbage on in_bit/in_last is ignored
      add(0,1,1,0,0, 1,1,2'b11,0);
      add(0,1,0,0,0, 0,1,2'b11,0);
      add(0,1,0,0,1, 1,1,2'b10,0);
      add(0,1,0,1,0, 0,1,2'b10,0);
      add(0,0,1,1,0, 0,1,2'b10,0);
      add(0,1,1,0,1, 1,1,2'b00,0);
      add(0,1,1,1,1, 1,1,2'b01,1);
      add(0,0,0,0,0, 0,1,2'b01,1);
      add(0,0,0,0,1, 1,0,2'b01,1);
      // reset after two accepted bits, then a single-bit frame
      add(0,1,1,0,1, 1,1,2'b11,0);
      add(0,1,1,0,1, 1,1,2'b01,0);
      add(1,0,0,0,0, 0,0,2'b00,0);
      add(0,1,1,1,0, 1,1,2'b11,1);
      add(0,0,0,0,1, 1,0,2'b11,1);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_in_ready",  -1, {1'b0, in_ready},  2'b01);
      chk("reset_out_valid", -1, {1'b0, out_valid}, 2'b00);
      chk("reset_out_sym",   -1, out_sym,           2'b00);
      chk("reset_out_last",  -1, {1'b0, out_last},  2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst       = tbl[i].rst;
         in_valid  = tbl[i].v;
         in_bit    = tbl[i].b;
         in_last   = tbl[i].l;
         out_ready = tbl[i].ordy;
         #1;
         chk("in_ready", i, {1'b0, in_ready}, {1'b0, tbl[i].irdy});
         @(posedge clk);
         #1;
         chk("out_valid", i, {1'b0, out_valid}, {1'b0, tbl[i].ov});
         chk("out_sym",   i, out_sym,           tbl[i].sym);
         chk("out_last",  i, {1'b0, out_last},  {1'b0, tbl[i].last});
      end

      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 feed-forward convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder. It accepts a stream of information bits over a valid/ready handshake and emits one 2-bit code symbol per accepted bit, in the same symbol format the decoder's branch-metric stage consumes. Frames are zero-terminated with K-1 tail bits, so the decoder can start and end every frame in state 0.

## Interface
- `K`, 3, constraint length; legal range 2..9.
- `G0`, 3'o7, K-bit generator polynomial for parity bit 0. Bit K-1 taps the current input; bit 0 taps the oldest history bit.
- `G1`, 3'o5, K-bit generator polynomial for parity bit 1, with the same bit ordering as `G0`.

Ports:
- `clk` input 1 — single clock; all logic is on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — `in_bit` and `in_last` are valid.
- `in_ready` output 1 — encoder accepts an input bit this cycle.
- `in_bit` input 1 — information bit.
- `in_last` input 1 — marks the final information bit of a frame.
- `out_valid` output 1 — `out_sym` and `out_last` are valid.
- `out_ready` input 1 — downstream accepts the symbol this cycle.
- `out_sym` output 2 — code symbol: `out_sym[1]` is the G0 parity, `out_sym[0]` is the G1 parity.
- `out_last` output 1 — marks the final symbol of a frame.

## Operation
- History register `sr[K-2:0]` holds the previous inputs: `sr[K-2]` is u(t-1) and `sr[0]` is u(t-K+1).
- Encode window `w = {u, sr}` (K bits).
- Parity: `p0 = ^(w & G0)`, `p1 = ^(w & G1)`.
- On each encode step, `sr <= w[K-1:1]`.
- State machine states: DATA and TAIL.
  - DATA: `in_ready = !out_valid || out_ready`. A transfer is `in_valid && in_ready`. On a transfer, encode with `u = in_bit` and load the output register.
    - If `in_last` is set, go to TAIL with tail counter `tc = K-1`.
    - `out_last` is 0 for symbols produced in DATA.
  - TAIL: `in_ready = 0`. Whenever the output register is free (`!out_valid || out_ready`), encode with `u = 0` and decrement `tc`.
    - On the step where `tc` goes 1→0, set `out_last = 1` and return to DATA.
    - After the final tail step, `sr` is all zeros.
- Output register: `out_sym` and `out_last` are loaded only on an encode step.
  - `out_valid` is set on an encode step.
  - `out_valid` is cleared when `out_ready` is high and no new encode occurs in the same cycle.
  - While `out_valid && !out_ready`, `out_sym` and `out_last` are held stable and no encode occurs.
- Simultaneous output drain and input accept in the same cycle is legal. This allows full throughput of one symbol per clock.
- `in_bit` and `in_last` are ignored when no transfer occurs.
- Reset, including mid-frame or mid-tail:
  - state DATA, `sr = 0`, `tc = 0`;
  - `out_valid = 0`, `out_sym = 2'b00`, `out_last = 0`;
  - `in_ready = 1` in the first cycle after reset.
  - Any pending symbol is discarded.

## Timing
- Latency: a symbol appears on `out_*` in the cycle after its input is accepted (one registered stage).
- Throughput: one symbol per clock when `out_ready` is held high.
- Frame of N information bits: exactly N+K-1 symbols. With continuous ready, there are K-1 cycles with `in_ready = 0` after the cycle in which `in_last` is accepted.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.

## Configuration
- `CONV_ENC_TAIL_EN` defined: zero-tail termination as described above; the TAIL state exists.
- Not defined:
  - TAIL state is removed and `in_ready` never drops for termination.
  - The symbol for the bit accepted with `in_last` carries `out_last = 1`.
  - On that same step, `sr` is cleared to 0 rather than shifted.
  - Frames are N symbols (truncated trellis).

## Test plan
- K=3, G0=7, G1=5, TAIL_EN, `out_ready = 1`; input 1,0,1,1 with `in_last` on the 4th bit → `out_sym` = 11,10,00,01,01,11. `out_last` is set only on the 6th symbol; `in_ready` is low for 2 cycles after the last bit is accepted.
- Single-bit frame: input 1 with `in_last` → 11,10,11, `out_last` on the third symbol. A second identical frame sent back-to-back gives the same output (history cleared by the tail).
- Backpressure: same stimulus as the first test with `out_ready` toggling 1,0,0,1,… → each symbol is held stable while stalled and no symbol is lost or duplicated. The sequence is still 11,10,00,01,01,11.
- `in_valid` asserted during TAIL with `in_bit = 1` → not accepted (`in_ready = 0`), and the tail symbols are unchanged.
- Reset asserted after 2 bits of a frame have been accepted → next cycle `out_valid = 0`, `out_sym = 00`, `in_ready = 1`. Then input 1 (`in_last`) → 11,10,11.
- Without `CONV_ENC_TAIL_EN`: input 1,0,1,1 (`in_last`) → 11,10,00,01 with `out_last` on 01. A following input 1 → 11.
